spn_encrypt_core: RTL and testbench

- Iterative substitution-permutation encryption engine; forward counterpart of the decryption substitution layer.
- Accepts one plaintext block plus key, executes ROUNDS rounds one per clock, presents the ciphertext on a valid/ready output.
- Sits between the block-input buffer and the ciphertext output stage of the encryption datapath.

---
 rtl/spn_pkg.sv | 25 ++
 rtl/spn_encrypt_core_if.sv | 22 ++
 rtl/spn_sbox_encrypt.sv | 11 +
 rtl/spn_encrypt_core.sv | 105 ++++++++++
 tb/tb_spn_encrypt_core.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spn_pkg.sv
// Shared types and constants for the SPN encryption core: FSM states,
// forward S-box table, key-schedule constants and the bit-permutation map.
package spn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam int ROT_AMT = 13;
    localparam int RC_W    = 5;

    // Destination of source bit i; the top bit is the fixed point.
    function automatic int perm_idx(input int i, input int n);
        if (i == n - 1) return n - 1;
        return (i * (n / 4)) % (n - 1);
    endfunction

endpackage

// File: rtl/spn_encrypt_core_if.sv
// Block-in / ciphertext-out handshake bundle for spn_encrypt_core.
interface spn_encrypt_core_if #(parameter int size = 64);

    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] plaintext;
    logic [size-1:0] key;
    logic            out_valid;
    logic            out_ready;
    logic [size-1:0] ciphertext;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext
    );

endinterface

// File: rtl/spn_sbox_encrypt.sv
// 4-bit combinational forward S-box, one instance per state nibble.
module spn_sbox_encrypt
    import spn_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/spn_encrypt_core.sv
// Iterative SPN encryption engine, one round per clock, valid/ready in and out.
// Optional macro SPN_ABORT_EN adds an abort input that drops the current block.
module spn_encrypt_core
    import spn_pkg::*;
#(
    parameter int size   = 64,
    parameter int ROUNDS = 31
)
(
    input  logic clk,
    input  logic rst_n,
`ifdef SPN_ABORT_EN
    input  logic abort,
`endif
    spn_encrypt_core_if.slave bus
);

    localparam int              NIB     = size / 4;
    localparam logic [RC_W-1:0] LAST_RC = RC_W'(ROUNDS);

    state_t          state, nstate;
    logic [size-1:0] st, rk, ct;
    logic [size-1:0] mix, sub, perm_o, rk_nxt;
    logic [RC_W-1:0] rc;
    logic            accept, abort_hit;

    assign mix = st ^ rk;

    genvar g;
    generate
        for (g = 0; g < NIB; g++) begin : g_sbox
            spn_sbox_encrypt u_sbox (
                .din  (mix[4*g +: 4]),
                .dout (sub[4*g +: 4])
            );
        end
        for (g = 0; g < size; g++) begin : g_perm
            localparam int J = perm_idx(g, size);
            assign perm_o[J] = sub[g];
        end
    endgenerate

    assign rk_nxt = {rk[size-ROT_AMT-1:0], rk[size-1:size-ROT_AMT]}
                  ^ {{(size-RC_W){1'b0}}, rc};

`ifdef SPN_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate        = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) nstate = RUN;
            end
            RUN: begin
                if (rc == LAST_RC) nstate = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        // Abort wins over the output handshake and over the final capture.
        if (abort_hit) nstate = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
            rk <= '0;
            ct <= '0;
            rc <= '0;
        end else if (accept) begin
            st <= bus.plaintext;
            rk <= bus.key;
            rc <= RC_W'(1);
        end else if (state == RUN) begin
            st <= perm_o;
            rk <= rk_nxt;
            // rc stops at ROUNDS so it never wraps; reloaded on the next accept.
            if (rc == LAST_RC) begin
                if (!abort_hit) ct <= perm_o ^ rk_nxt;
            end else begin
                rc <= rc + 1'b1;
            end
        end
    end

    assign bus.ciphertext = ct;

endmodule

// File: tb/tb_spn_encrypt_core.sv
// Scoreboard bench for spn_encrypt_core: 64/31, 64/1 and 128/31 instances
// checked against an independent reference model of the cipher.
module tb_spn_encrypt_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] FS [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    logic [127:0] qa[$];
    logic [127:0] qb[$];
    logic [127:0] qc[$];

    spn_encrypt_core_if #(.size(64))  ia();
    spn_encrypt_core_if #(.size(64))  ib();
    spn_encrypt_core_if #(.size(128)) ic();

`ifdef SPN_ABORT_EN
    logic abort_a = 1'b0, abort_b = 1'b0, abort_c = 1'b0;
`endif

    spn_encrypt_core #(.size(64), .ROUNDS(31)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SPN_ABORT_EN
        .abort (abort_a),
`endif
        .bus   (ia)
    );

    spn_encrypt_core #(.size(64), .ROUNDS(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SPN_ABORT_EN
        .abort (abort_b),
`endif
        .bus   (ib)
    );

    spn_encrypt_core #(.size(128), .ROUNDS(31)) u_c (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SPN_ABORT_EN
        .abort (abort_c),
`endif
        .bus   (ic)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] m_sub(input logic [127:0] x, input int n);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < n / 4; i++) y[4*i +: 4] = FS[x[4*i +: 4]];
        return y;
    endfunction

    function automatic logic [127:0] m_perm(input logic [127:0] x, input int n);
        logic [127:0] y;
        int j;
        y = '0;
        for (int i = 0; i < n; i++) begin
            j = (i == n - 1) ? i : (i * (n / 4)) % (n - 1);
            y[j] = x[i];
        end
        return y;
    endfunction

    function automatic logic [127:0] m_rotl(input logic [127:0] x, input int n);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < n; i++) y[(i + 13) % n] = x[i];
        return y;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key,
                                         input int n, input int rounds);
        logic [127:0] s, k, t, kn;
        s = pt;
        k = key;
        for (int r = 1; r <= rounds; r++) begin
            t  = m_perm(m_sub(s ^ k, n), n);
            kn = m_rotl(k, n) ^ 128'(r);
            if (r == rounds) return t ^ kn;
            s = t;
            k = kn;
        end
        return '0;
    endfunction

    // Scoreboard monitors: pop on every completed output handshake.
    always @(negedge clk) if (rst_n && ia.out_valid && ia.out_ready) begin
        if (qa.size() == 0) chk("a_spurious_out", 128'(1), 128'(0));
        else chk("a_ct", {64'b0, ia.ciphertext}, qa.pop_front());
    end
    always @(negedge clk) if (rst_n && ib.out_valid && ib.out_ready) begin
        if (qb.size() == 0) chk("b_spurious_out", 128'(1), 128'(0));
        else chk("b_ct", {64'b0, ib.ciphertext}, qb.pop_front());
    end
    always @(negedge clk) if (rst_n && ic.out_valid && ic.out_ready) begin
        if (qc.size() == 0) chk("c_spurious_out", 128'(1), 128'(0));
        else chk("c_ct", ic.ciphertext, qc.pop_front());
    end

    task automatic start_a(input logic [63:0] pt, input logic [63:0] k);
        int n;
        n = 0;
        while (!ia.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("a_idle_before_accept", 128'(ia.in_ready), 128'(1));
        ia.in_valid  = 1'b1;
        ia.plaintext = pt;
        ia.key       = k;
        qa.push_back(enc({64'b0, pt}, {64'b0, k}, 64, 31));
        @(posedge clk); #1;
        ia.in_valid  = 1'b0;
        ia.plaintext = {$urandom, $urandom};
        ia.key       = {$urandom, $urandom};
    endtask

    task automatic wait_out_a(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (!ia.out_valid && n < 200) begin
            if (ia.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; n++;
        end
        if (ia.in_ready) rdy_seen = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit rdy_seen, stable, ov_seen;
        logic [63:0]  hold;
        logic [127:0] p, k;

        ia.in_valid = 0; ia.plaintext = '0; ia.key = '0; ia.out_ready = 1;
        ib.in_valid = 0; ib.plaintext = '0; ib.key = '0; ib.out_ready = 1;
        ic.in_valid = 0; ic.plaintext = '0; ic.key = '0; ic.out_ready = 1;

        #1;
        chk("rst_in_ready", 128'(ia.in_ready), 128'(1));
        chk("rst_out_valid", 128'(ia.out_valid), 128'(0));
        chk("rst_ct", {64'b0, ia.ciphertext}, 128'(0));
        chk("rst_c_ct", ic.ciphertext, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ROUNDS=1 known answer, with out_ready already high at DONE entry.
        ib.in_valid = 1'b1;
        qb.push_back(128'h0000_0000_0000_0000_FFFF_FFFF_0000_0001);
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        chk("b_in_ready_run", 128'(ib.in_ready), 128'(0));
        chk("b_out_valid_run", 128'(ib.out_valid), 128'(0));
        @(posedge clk); #1;
        chk("b_out_valid_lat1", 128'(ib.out_valid), 128'(1));
        @(posedge clk); #1;
        chk("b_idle_after_hs", 128'(ib.in_ready), 128'(1));
        chk("b_ov_after_hs", 128'(ib.out_valid), 128'(0));

        // 128-bit instance: zero vector then random vectors.
        for (int v = 0; v < 3; v++) begin
            p = (v == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            k = (v == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            ic.in_valid = 1'b1; ic.plaintext = p; ic.key = k;
            qc.push_back(enc(p, k, 128, 31));
            @(posedge clk); #1;
            ic.in_valid = 1'b0;
            n = 0;
            while (!ic.out_valid && n < 200) begin @(posedge clk); #1; n++; end
            chk("c_latency", 128'(n), 128'(31));
            @(posedge clk); #1;
        end

        // Random blocks on the 64/31 instance with out_ready held high.
        for (int b = 0; b < 1000; b++) begin
            start_a({$urandom, $urandom}, {$urandom, $urandom});
            wait_out_a(n, rdy_seen);
            chk("a_latency", 128'(n), 128'(31));
            chk("a_in_ready_busy", 128'(rdy_seen), 128'(0));
            @(posedge clk); #1;
        end

        // Backpressure: ciphertext held, in_valid pulses ignored.
        ia.out_ready = 1'b0;
        start_a({$urandom, $urandom}, {$urandom, $urandom});
        wait_out_a(n, rdy_seen);
        chk("bp_latency", 128'(n), 128'(31));
        hold = ia.ciphertext;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ia.in_valid  = i[0];
            ia.plaintext = {$urandom, $urandom};
            @(posedge clk); #1;
            if (!ia.out_valid || ia.ciphertext !== hold || ia.in_ready) stable = 1'b0;
        end
        ia.in_valid = 1'b0;
        chk("bp_stable", 128'(stable), 128'(1));
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", 128'(ia.in_ready), 128'(1));
        chk("bp_ov_clear", 128'(ia.out_valid), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_extra_accept", 128'(ia.in_ready), 128'(1));

        // Asynchronous reset in the middle of a block.
        start_a({$urandom, $urandom}, {$urandom, $urandom});
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(ia.in_ready), 128'(1));
        chk("mid_rst_ov", 128'(ia.out_valid), 128'(0));
        chk("mid_rst_ct", {64'b0, ia.ciphertext}, 128'(0));
        void'(qa.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_a(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        wait_out_a(n, rdy_seen);
        chk("post_rst_latency", 128'(n), 128'(31));
        @(posedge clk); #1;

`ifdef SPN_ABORT_EN
        // Abort during RUN: back to IDLE, block dropped, no output.
        start_a({$urandom, $urandom}, {$urandom, $urandom});
        repeat (4) @(posedge clk);
        #1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort_run_idle", 128'(ia.in_ready), 128'(1));
        chk("abort_run_ov", 128'(ia.out_valid), 128'(0));
        void'(qa.pop_back());
        ov_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ia.out_valid) ov_seen = 1'b1;
        end
        chk("abort_no_ov", 128'(ov_seen), 128'(0));

        // Abort coinciding with out_ready in DONE.
        ia.out_ready = 1'b0;
        start_a({$urandom, $urandom}, {$urandom, $urandom});
        wait_out_a(n, rdy_seen);
        hold = ia.ciphertext;
        abort_a = 1'b1;
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort_done_idle", 128'(ia.in_ready), 128'(1));
        chk("abort_done_ov", 128'(ia.out_valid), 128'(0));
        chk("abort_done_ct_kept", {64'b0, ia.ciphertext}, {64'b0, hold});
        @(posedge clk); #1;
        chk("abort_done_still_idle", 128'(ia.in_ready), 128'(1));
`else
        ov_seen = 1'b0;
`endif

        chk("qa_drained", 128'(qa.size()), 128'(0));
        chk("qb_drained", 128'(qb.size()), 128'(0));
        chk("qc_drained", 128'(qc.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
